inst_decoder: RTL

//  Receiving end of the 34-bit core instruction bus. Registers inst_in, splits it into
//  per-unit strobes, enforces sequencing legality (weight load -> execute -> drain) with a

---
 rtl/inst_decoder_if.sv | 10 +
 rtl/inst_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_decoder_if.sv
// Instruction bus from the host into the decoder, bundled with the core status
// feedback (OFIFO valid, L0 full) that gates the decoded strobes.
interface inst_decoder_if;
    logic [33:0] inst_in;
    logic        ofifo_valid;
    logic        l0_full;

    modport master (output inst_in, output ofifo_valid, output l0_full);
    modport slave  (input  inst_in, input  ofifo_valid, input  l0_full);
endinterface

// File: rtl/inst_decoder.sv
// Instruction decoder: registers the 34-bit instruction, gates illegal strobes and
// tracks the weight-load -> execute -> drain phase. Define INST_DEC_ERR_LOG_EN to log the first error code.
module inst_decoder #(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int LEN_NIJ = 36,
    parameter int ADDR_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    inst_decoder_if.slave     bus,
    output logic              acc,
    output logic              pmem_cen,
    output logic              pmem_wen,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic              xmem_cen,
    output logic              xmem_wen,
    output logic [ADDR_W-1:0] xmem_addr,
    output logic              ofifo_rd,
    output logic              ififo_wr,
    output logic              ififo_rd,
    output logic              l0_rd,
    output logic              l0_wr,
    output logic              execute,
    output logic              load,
    output logic [2:0]        phase,
    output logic              pass_done,
    output logic              err,
    output logic              err_sticky,
    output logic [3:0]        err_code
);
    localparam int LCW = $clog2(ROW + 1);
    localparam int ECW = $clog2(LEN_NIJ + 1);
    localparam int L0W = $clog2(COL + 1) + 1;
    localparam logic [LCW-1:0] ROW_C = LCW'(ROW);
    localparam logic [ECW-1:0] LEN_C = ECW'(LEN_NIJ);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L0FILL = 3'd1,
        KLOAD  = 3'd2,
        EXEC   = 3'd3,
        DRAIN  = 3'd4
    } phase_e;

    // Bit i of causes corresponds to error code i+1; lowest code wins.
    function automatic logic [3:0] first_cause(input logic [5:0] causes);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 5; i >= 0; i--) begin
            if (causes[i]) begin
                code = 4'(i + 1);
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

    phase_e           state_r, state_nxt_s;
    logic [LCW-1:0]   load_cnt_r, load_cnt_nxt_s;
    logic [ECW-1:0]   exec_cnt_r, exec_cnt_nxt_s;
    logic [L0W-1:0]   l0_cnt_r, l0_cnt_nxt_s;
    logic             ld_s, ex_s, l0w_s, ofr_s, both_s, ex_legal_s, xw_s;
    logic             ld_ok_s, ex_ok_s, l0w_ok_s, ofr_ok_s, xw_bad_s;
    logic             pass_done_s;
    logic [5:0]       causes_s;
    logic [3:0]       code_s;

    // Classify the incoming instruction against the current phase.
    always_comb begin
        ld_s       = bus.inst_in[0];
        ex_s       = bus.inst_in[1];
        l0w_s      = bus.inst_in[2];
        ofr_s      = bus.inst_in[6];
        xw_s       = ~bus.inst_in[19] & ~bus.inst_in[18];
        both_s     = ld_s & ex_s;
        ex_legal_s = ((state_r == KLOAD) && (load_cnt_r == ROW_C)) || (state_r == EXEC);
        causes_s[0] = both_s;
        causes_s[1] = ofr_s & ~bus.ofifo_valid;
        causes_s[2] = l0w_s & bus.l0_full;
        causes_s[5] = ex_s & ~both_s & (state_r == DRAIN);
        causes_s[3] = ex_s & ~both_s & ~causes_s[5] & ~ex_legal_s;
        causes_s[4] = xw_s & ((state_r == KLOAD) || (state_r == EXEC));
        code_s      = first_cause(causes_s);
        ld_ok_s    = ld_s & ~both_s;
        ex_ok_s    = ex_s & ~causes_s[0] & ~causes_s[3] & ~causes_s[5];
        l0w_ok_s   = l0w_s & ~causes_s[2];
        ofr_ok_s   = ofr_s & ~causes_s[1];
        xw_bad_s   = causes_s[4];
    end

    // Phase transitions and sequencing counters.
    always_comb begin
        state_nxt_s    = state_r;
        exec_cnt_nxt_s = exec_cnt_r;
        pass_done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (l0w_ok_s) state_nxt_s = L0FILL;
                else          state_nxt_s = IDLE;
            end
            L0FILL: begin
                if (ld_ok_s) state_nxt_s = KLOAD;
                else         state_nxt_s = L0FILL;
            end
            KLOAD: begin
                if (ex_ok_s) begin
                    state_nxt_s    = EXEC;
                    exec_cnt_nxt_s = exec_cnt_r + 1'b1;
                end else begin
                    state_nxt_s = KLOAD;
                end
            end
            EXEC: begin
                if (ex_ok_s && (exec_cnt_r + 1'b1 == LEN_C)) begin
                    state_nxt_s    = DRAIN;
                    exec_cnt_nxt_s = '0;
                    pass_done_s    = 1'b1;
                end else if (ex_ok_s) begin
                    exec_cnt_nxt_s = exec_cnt_r + 1'b1;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            DRAIN: begin
                if (l0w_ok_s)                           state_nxt_s = L0FILL;
                else if (!bus.ofifo_valid && !ofr_s)    state_nxt_s = IDLE;
                else                                    state_nxt_s = DRAIN;
            end
            default: begin
                state_nxt_s    = IDLE;
                exec_cnt_nxt_s = '0;
            end
        endcase

        if ((state_nxt_s == L0FILL) && (state_r != L0FILL)) begin
            load_cnt_nxt_s = '0;
            l0_cnt_nxt_s   = '0;
        end else begin
            if (ld_ok_s && (load_cnt_r != ROW_C)) load_cnt_nxt_s = load_cnt_r + 1'b1;
            else                                  load_cnt_nxt_s = load_cnt_r;
            if (l0w_ok_s && (l0_cnt_r != '1))     l0_cnt_nxt_s   = l0_cnt_r + 1'b1;
            else                                  l0_cnt_nxt_s   = l0_cnt_r;
        end
    end

    // Phase register and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            load_cnt_r <= '0;
            exec_cnt_r <= '0;
            l0_cnt_r   <= '0;
        end else begin
            state_r    <= state_nxt_s;
            load_cnt_r <= load_cnt_nxt_s;
            exec_cnt_r <= exec_cnt_nxt_s;
            l0_cnt_r   <= l0_cnt_nxt_s;
        end
    end

    // Registered core-facing outputs; memory fields pass through except blocked xmem writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc        <= 1'b0;
            pmem_cen   <= 1'b1;
            pmem_wen   <= 1'b1;
            pmem_addr  <= '0;
            xmem_cen   <= 1'b1;
            xmem_wen   <= 1'b1;
            xmem_addr  <= '0;
            ofifo_rd   <= 1'b0;
            ififo_wr   <= 1'b0;
            ififo_rd   <= 1'b0;
            l0_rd      <= 1'b0;
            l0_wr      <= 1'b0;
            execute    <= 1'b0;
            load       <= 1'b0;
            pass_done  <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            acc        <= bus.inst_in[33];
            pmem_cen   <= bus.inst_in[32];
            pmem_wen   <= bus.inst_in[31];
            pmem_addr  <= bus.inst_in[20 +: ADDR_W];
            xmem_cen   <= bus.inst_in[19] | xw_bad_s;
            xmem_wen   <= bus.inst_in[18] | xw_bad_s;
            xmem_addr  <= bus.inst_in[7 +: ADDR_W];
            ofifo_rd   <= ofr_ok_s;
            ififo_wr   <= bus.inst_in[5];
            ififo_rd   <= bus.inst_in[4];
            l0_rd      <= bus.inst_in[3];
            l0_wr      <= l0w_ok_s;
            execute    <= ex_ok_s;
            load       <= ld_ok_s;
            pass_done  <= pass_done_s;
            err        <= (code_s != 4'd0);
            err_sticky <= err_sticky | (code_s != 4'd0);
        end
    end

    // Error code log: first error since reset is frozen when logging is built in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_code <= 4'd0;
        end else begin
`ifdef INST_DEC_ERR_LOG_EN
            if (err_code == 4'd0) err_code <= code_s;
            else                  err_code <= err_code;
`else
            err_code <= 4'd0;
`endif
        end
    end

    assign phase = state_r;
endmodule
